// File: rtl/uart_bram_fifo.sv
// First-word-fall-through FIFO built on a simple dual-port block RAM.
// It uses a two-stage read path: a RAM output register, then the rd_data prefetch register.
module uart_bram_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 64,
  parameter int AFULL_THRESH  = MEM_DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic                         almost_empty,
  output logic [$clog2(MEM_DEPTH):0]   count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(MEM_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, ram_cnt_q, ram_cnt_d;
  logic                  ram_vld_q, ram_vld_d, rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  full_w, wr_acc, pop, s2_load, rd_issue;

  // All acceptance decisions use pre-edge state only
  assign full_w   = (count_q == DEPTH_C);
  assign wr_acc   = wr_en & ~full_w;
  assign pop      = rd_en & rd_valid_q;
  assign s2_load  = ram_vld_q & (~rd_valid_q | pop);
  // ram_cnt_q counts words still in RAM, so an issued read never targets the slot being written
  assign rd_issue = (ram_cnt_q != '0) & (~ram_vld_q | s2_load);

  always_comb begin
    wr_ptr_d   = wr_acc   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = rd_issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ram_cnt_d  = ram_cnt_q + CW'(wr_acc) - CW'(rd_issue);
    count_d    = count_q + CW'(wr_acc) - CW'(pop);
    ram_vld_d  = rd_issue | (ram_vld_q & ~s2_load);
    rd_valid_d = s2_load | (rd_valid_q & ~pop);
    rd_data_d  = s2_load ? ram_q : rd_data_q;
    ovf_d      = (ovf_q & ~clr_err) | (wr_en & full_w);
    udf_d      = (udf_q & ~clr_err) | (rd_en & ~rd_valid_q);
  end

  always_ff @(posedge clk) begin
    if (wr_acc)   mem[wr_ptr_q] <= wr_data;
    if (rd_issue) ram_q         <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      ram_vld_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
      ram_vld_q  <= ram_vld_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign full         = full_w;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
endmodule

// File: tb/tb_uart_bram_fifo.sv
// Directed bench for uart_bram_fifo: depth 8, thresholds 6/2, 8-bit words.
module tb_uart_bram_fifo;
  logic       clk = 1'b0;
  logic       rst_n, wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic       full, almost_full, rd_valid, almost_empty, overflow, underflow;
  logic [7:0] rd_data;
  logic [3:0] count;
  int         total = 0;
  int         bad = 0;

  uart_bram_fifo #(.DATA_WIDTH(8), .MEM_DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    step(); step();
    total++;
    if ({count, rd_valid, rd_data, full, almost_full, almost_empty, overflow, underflow} !==
        {4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: count=%0d vld=%b data=%h full=%b af=%b ae=%b ovf=%b udf=%b",
               count, rd_valid, rd_data, full, almost_full, almost_empty, overflow, underflow);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || count !== 4'd1) begin
      bad++; $display("FAIL single_e0: vld=%b count=%0d expected vld=0 count=1", rd_valid, count);
    end
    step();
    total++;
    if (rd_valid !== 1'b0) begin
      bad++; $display("FAIL single_e1: vld=%b expected 0", rd_valid);
    end
    step();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || count !== 4'd1 || almost_empty !== 1'b1) begin
      bad++;
      $display("FAIL single_e2: vld=%b data=%h count=%0d ae=%b expected 1 a5 1 1",
               rd_valid, rd_data, count, almost_empty);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || count !== 4'd0) begin
      bad++; $display("FAIL single_pop: vld=%b count=%0d expected 0 0", rd_valid, count);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      total++;
      if (count !== 4'(i) || almost_full !== (i >= 6) || full !== (i == 8)) begin
        bad++;
        $display("FAIL fill_%0d: count=%0d af=%b full=%b expected %0d %b %b",
                 i, count, almost_full, full, i, (i >= 6), (i == 8));
      end
    end
    wr_data = 8'h09;
    step();
    wr_en = 1'b0;
    total++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      bad++; $display("FAIL overflow: ovf=%b count=%0d expected 1 8", overflow, count);
    end
    for (int i = 1; i <= 8; i++) begin
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        bad++; $display("FAIL drain_%0d: vld=%b data=%h expected 1 %h", i, rd_valid, rd_data, 8'(i));
      end
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || count !== 4'd0 || almost_empty !== 1'b1) begin
      bad++; $display("FAIL drained: vld=%b count=%0d ae=%b expected 0 0 1", rd_valid, count, almost_empty);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    total++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL ovf_clear: ovf=%b udf=%b expected 0 0", overflow, underflow);
    end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    step(); step(); step();
    total++;
    if (underflow !== 1'b1 || count !== 4'd0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL underflow: udf=%b count=%0d vld=%b expected 1 0 0", underflow, count, rd_valid);
    end
    clr_err = 1'b1;
    step();
    total++;
    if (underflow !== 1'b1) begin
      bad++; $display("FAIL set_wins: udf=%b expected 1", underflow);
    end
    rd_en = 1'b0;
    step();
    clr_err = 1'b0;
    total++;
    if (underflow !== 1'b0) begin
      bad++; $display("FAIL udf_clear: udf=%b expected 0", underflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i); q.push_back(wr_data);
      step();
    end
    wr_en = 1'b0;
    step(); step();
    for (int i = 0; i < 20; i++) begin
      exp = q.pop_front();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp || count !== 4'd4) begin
        bad++;
        $display("FAIL b2b_%0d: vld=%b data=%h count=%0d expected 1 %h 4", i, rd_valid, rd_data, count, exp);
      end
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h20 + 8'(i); q.push_back(wr_data);
      step();
    end
    wr_en = 1'b0;
    total++;
    if (count !== 4'd4) begin
      bad++; $display("FAIL b2b_count: count=%0d expected 4", count);
    end
    for (int i = 0; i < 4; i++) begin
      exp = q.pop_front();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        bad++; $display("FAIL b2b_tail_%0d: vld=%b data=%h expected 1 %h", i, rd_valid, rd_data, exp);
      end
      step();
    end
    rd_en = 1'b0;
    total++;
    if (count !== 4'd0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_empty: count=%0d vld=%b expected 0 0", count, rd_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    step(); step();
    total++;
    if (count !== 4'd5 || rd_data !== 8'h50) begin
      bad++; $display("FAIL pre_rst: count=%0d data=%h expected 5 50", count, rd_data);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({count, rd_valid, rd_data, full, almost_full, almost_empty, overflow, underflow} !==
        {4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset: count=%0d vld=%b data=%h full=%b af=%b ae=%b ovf=%b udf=%b",
               count, rd_valid, rd_data, full, almost_full, almost_empty, overflow, underflow);
    end
    #1 rst_n = 1'b1;
    step();
    wr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    step(); step();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C || count !== 4'd1) begin
      bad++; $display("FAIL post_rst: vld=%b data=%h count=%0d expected 1 3c 1", rd_valid, rd_data, count);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    step(); step();
    total++;
    if (rd_valid !== 1'b0 || count !== 4'd0) begin
      bad++; $display("FAIL no_stale: vld=%b data=%h count=%0d expected 0 0", rd_valid, rd_data, count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_bram_fifo.md
UART_BRAM_FIFO -- requirements
Module: uart_bram_fifo

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the width of each stored word.
REQ-002 The module SHALL have parameter MEM_DEPTH, default 64, meaning total word capacity; it SHALL be a power of 2 and at least 4.
REQ-003 The module SHALL have parameter AFULL_THRESH, default MEM_DEPTH-4, meaning almost_full asserts when count >= AFULL_THRESH.
REQ-004 The module SHALL have parameter AEMPTY_THRESH, default 4, meaning almost_empty asserts when count <= AEMPTY_THRESH.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  DATA_WIDTH  write word.
REQ-009 full  output  1  count == MEM_DEPTH.
REQ-010 almost_full  output  1  count >= AFULL_THRESH.
REQ-011 rd_en  input  1  pop request; honoured only when rd_valid=1.
REQ-012 rd_data  output  DATA_WIDTH  head word, registered, first-word-fall-through.
REQ-013 rd_valid  output  1  rd_data holds the valid head word (not empty).
REQ-014 almost_empty  output  1  count <= AEMPTY_THRESH.
REQ-015 count  output  $clog2(MEM_DEPTH)+1  words held, including the word in rd_data.
REQ-016 overflow  output  1  sticky; a write was attempted while full.
REQ-017 underflow  output  1  sticky; a read was attempted while rd_valid=0.
REQ-018 clr_err  input  1  synchronous clear of overflow and underflow.

Function
REQ-019 Storage SHALL be a simple dual-port block RAM (one write port, one registered read port), not registers, plus one output prefetch register driving rd_data.
REQ-020 A write is accepted at the edge where wr_en=1 and full=0; wr_data is written at wr_ptr, and wr_ptr increments modulo MEM_DEPTH.
REQ-021 A pop is accepted at the edge where rd_en=1 and rd_valid=1; the prefetch register is reloaded from RAM at the next opportunity.
REQ-022 Fall-through latency: a word accepted at edge E into an empty FIFO SHALL appear on rd_data with rd_valid=1 after edge E+2.
REQ-023 With back-to-back pops and data in RAM, rd_valid SHALL stay 1 and a new head SHALL appear every cycle (one-word RAM lookahead).
REQ-024 count SHALL increment on write-only, decrement on pop-only, and hold when a write and a pop are accepted on the same edge.
REQ-025 full and the flags SHALL be evaluated from pre-edge state: a write while full is rejected even if a pop is accepted on the same edge.
REQ-026 A rejected write SHALL set overflow; a rd_en with rd_valid=0 SHALL set underflow; neither SHALL change the pointers, count or data.
REQ-027 clr_err=1 SHALL clear both sticky flags; if a new error occurs on the same edge, set SHALL win.
REQ-028 Pointer wrap from MEM_DEPTH-1 to 0 SHALL be seamless with no lost or duplicated words.
REQ-029 Data order SHALL be strictly first-in first-out.

Reset
REQ-030 While rst_n=0, asynchronously: pointers=0, count=0, rd_valid=0, rd_data=0, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0.
REQ-031 RAM contents SHALL NOT be cleared; reset mid-operation discards all held words, and the first write after release follows REQ-022.

Verification (bench MEM_DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2, DATA_WIDTH=8)
REQ-032 Reset, then write 0xA5 once -> rd_valid=1 with rd_data=0xA5 two edges later; count=1; almost_empty=1.
REQ-033 Write 0x01..0x08 -> full=1, count=8, almost_full=1 from the 6th write; a 9th write of 0x09 -> overflow=1 and count stays 8; continuous pops return 0x01..0x08 in order, one per cycle.
REQ-034 Hold rd_en=1 continuously with FIFO empty -> underflow=1, count=0; pulse clr_err -> underflow=0.
REQ-035 At count=4, simultaneous write and pop for 20 cycles (pointers wrap twice) -> count stays 4 and the output sequence equals the input sequence.
REQ-036 At count=5, assert rst_n=0 mid-cycle -> all outputs take their reset values immediately; after release, write 0x3C -> rd_data=0x3C and no old data reappears.
